// File: rtl/rc_pwm_transmitter_pkg.sv
// Shared types, constants and width helper for the RC PWM transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rc_pwm_transmitter_pkg;

    localparam int VAL_W  = 8;     // bits per channel value
    localparam int NUM_CH = 4;     // throttle, yaw, roll, pitch
    localparam int CNT_W  = 15;    // frame counter width, covers frames up to 32767 us
    localparam int PW_W   = 12;    // pulse width width, max 1000 + 255*4 = 2020 fits

    typedef logic [VAL_W-1:0]             ch_val_t;
    typedef logic [NUM_CH-1:0][VAL_W-1:0] ch_set_t;   // index 0 = throttle .. 3 = pitch
    typedef logic [1:0]                   ch_idx_t;
    typedef logic [PW_W-1:0]              pw_t;
    typedef logic [CNT_W-1:0]             frame_cnt_t;

    localparam ch_idx_t CH_THROTTLE = 2'd0;
    localparam ch_idx_t CH_YAW      = 2'd1;
    localparam ch_idx_t CH_ROLL     = 2'd2;
    localparam ch_idx_t CH_PITCH    = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_PULSE = 2'd1,
        TX_GAP   = 2'd2
    } tx_state_t;

    // Pulse width in us for a channel value: min_us + (val << shift).
    function automatic pw_t pulse_width(input ch_val_t val, input int min_us, input int shift);
        return pw_t'(min_us) + (pw_t'(val) << shift);
    endfunction

endpackage

// File: rtl/rc_pwm_transmitter_if.sv
// Channel-set input handshake and PWM/status outputs of the transmitter.
// Latency: n/a (wiring only).
// Backpressure: in_ready drops for the single load cycle of each frame and during reset.
//  master: channel source (drives values/in_valid, observes outputs)
//  slave : transmitter (accepts values, drives pulses/status)
interface rc_pwm_transmitter_if;
    import rc_pwm_transmitter_pkg::*;

    logic    in_valid;
    logic    in_ready;
    ch_val_t throttle_val;
    ch_val_t yaw_val;
    ch_val_t roll_val;
    ch_val_t pitch_val;
    logic    throttle_pwm;
    logic    yaw_pwm;
    logic    roll_pwm;
    logic    pitch_pwm;
    logic    frame_start;
    logic    busy;

    modport master (
        output in_valid, throttle_val, yaw_val, roll_val, pitch_val,
        input  in_ready, throttle_pwm, yaw_pwm, roll_pwm, pitch_pwm, frame_start, busy
    );

    modport slave (
        input  in_valid, throttle_val, yaw_val, roll_val, pitch_val,
        output in_ready, throttle_pwm, yaw_pwm, roll_pwm, pitch_pwm, frame_start, busy
    );

endinterface

// File: rtl/rc_pwm_transmitter_frame_timer.sv
// Free-running frame counter 0..FRAME_US-1; flags the last cycle of each frame (load edge).
// Latency: load_edge/in_ready are combinational from the counter register.
// Backpressure: in_ready is low during reset and in the load cycle so the shadow set is stable when copied.
//  ports: us_clk, resetn (async active-low) in; load_edge, in_ready out
module rc_pwm_transmitter_frame_timer
    import rc_pwm_transmitter_pkg::*;
#(
    parameter int FRAME_US = 20000
) (
    input  logic us_clk,
    input  logic resetn,
    output logic load_edge,
    output logic in_ready
);

    localparam frame_cnt_t LAST_CNT = frame_cnt_t'(FRAME_US - 1);

    frame_cnt_t frame_cnt;

    // Runs regardless of enable so frames always stay on a fixed grid.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            frame_cnt <= '0;
        end else if (frame_cnt == LAST_CNT) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + frame_cnt_t'(1);
        end
    end

    assign load_edge = (frame_cnt == LAST_CNT);
    assign in_ready  = resetn && !load_edge;

endmodule

// File: rtl/rc_pwm_transmitter.sv
// Four-channel servo PWM encoder: staggered pulses, one channel high at a time, once per frame.
// Latency: frame_start/throttle_pwm rise on the clock edge that ends the frame's last cycle.
// Backpressure: shadow regs accept any cycle except the load cycle (and reset); later accepts overwrite.
//  ports: us_clk (1 MHz), resetn (async active-low), enable (sampled at load edge),
//         bus (slave modport: value handshake in, pwm/frame_start/busy out)
module rc_pwm_transmitter
    import rc_pwm_transmitter_pkg::*;
#(
    parameter int FRAME_US     = 20000,   // 8081..32767; four max pulses (8080) must fit in a frame
    parameter int MIN_PULSE_US = 1000,
    parameter int STEP_SHIFT   = 2
) (
    input  logic                   us_clk,
    input  logic                   resetn,
    input  logic                   enable,
    rc_pwm_transmitter_if.slave    bus
);

    logic      load_edge;
    logic      in_ready;
    ch_set_t   shadow;
    ch_set_t   active;
    tx_state_t state;
    ch_idx_t   ch;
    ch_idx_t   ch_nxt;
    pw_t       rem;          // cycles left in the current pulse after this one
    pw_t       nxt_w;
    logic [NUM_CH-1:0] pwm;
    logic      frame_start;
    logic      busy;

    rc_pwm_transmitter_frame_timer #(
        .FRAME_US (FRAME_US)
    ) u_timer (
        .us_clk    (us_clk),
        .resetn    (resetn),
        .load_edge (load_edge),
        .in_ready  (in_ready)
    );

    assign bus.in_ready = in_ready;

    // Shadow set: all four values latched together.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            shadow <= '0;
        end else if (bus.in_valid && in_ready) begin
            shadow <= {bus.pitch_val, bus.roll_val, bus.yaw_val, bus.throttle_val};
        end
    end

    assign ch_nxt = ch + 2'd1;
    assign nxt_w  = pulse_width(active[ch_nxt], MIN_PULSE_US, STEP_SHIFT);

    // Pulse sequencer. The load loads rem with w0-1 so the pulse is high for
    // exactly w0 cycles; the hand-off to the next channel happens on the same
    // edge that drops the previous one, giving no overlap and no gap.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state       <= TX_IDLE;
            ch          <= CH_THROTTLE;
            rem         <= '0;
            active      <= '0;
            pwm         <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                TX_IDLE, TX_GAP: begin
                    if (load_edge) begin
                        if (enable) begin
                            active      <= shadow;
                            state       <= TX_PULSE;
                            ch          <= CH_THROTTLE;
                            rem         <= pulse_width(shadow[CH_THROTTLE], MIN_PULSE_US, STEP_SHIFT)
                                           - pw_t'(1);
                            pwm         <= 4'b0001;
                            frame_start <= 1'b1;
                            busy        <= 1'b1;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end
                end
                TX_PULSE: begin
                    if (rem == '0) begin
                        if (ch == CH_PITCH) begin
                            state <= TX_GAP;
                            pwm   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            ch  <= ch_nxt;
                            pwm <= 4'b0001 << ch_nxt;
                            rem <= nxt_w - pw_t'(1);
                        end
                    end else begin
                        rem <= rem - pw_t'(1);
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    pwm   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.throttle_pwm = pwm[CH_THROTTLE];
    assign bus.yaw_pwm      = pwm[CH_YAW];
    assign bus.roll_pwm     = pwm[CH_ROLL];
    assign bus.pitch_pwm    = pwm[CH_PITCH];
    assign bus.frame_start  = frame_start;
    assign bus.busy         = busy;

endmodule

// File: tb/tb_rc_pwm_transmitter.sv
// Bench for rc_pwm_transmitter: frame-level reference model compared every cycle,
// plus event timestamps checked against hand-computed literals.
module tb_rc_pwm_transmitter;

    localparam int F = 8200;   // short frame keeps the run compact; still >= 8081

    logic us_clk = 1'b0;
    logic resetn = 1'b1;
    logic enable = 1'b1;

    rc_pwm_transmitter_if bus ();

    rc_pwm_transmitter #(
        .FRAME_US     (F),
        .MIN_PULSE_US (1000),
        .STEP_SHIFT   (2)
    ) dut (
        .us_clk (us_clk),
        .resetn (resetn),
        .enable (enable),
        .bus    (bus)
    );

    always #5 us_clk = ~us_clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model (frame arithmetic) ----------------
    int cyc  = 0;              // rising edges since reset release
    int base = -1;             // edge number of the latest frame start, -1 = none yet
    int m_sh [4] = '{0, 0, 0, 0};
    int mw   [4] = '{1000, 1000, 1000, 1000};

    always @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            cyc  = 0;
            base = -1;
            for (int k = 0; k < 4; k++) m_sh[k] = 0;
        end else begin
            cyc++;
            if (cyc % F == 0) begin
                if (enable) begin
                    base = cyc;
                    for (int k = 0; k < 4; k++) mw[k] = 1000 + 4 * m_sh[k];
                end
            end else if (bus.in_valid) begin
                m_sh[0] = int'(bus.throttle_val);
                m_sh[1] = int'(bus.yaw_val);
                m_sh[2] = int'(bus.roll_val);
                m_sh[3] = int'(bus.pitch_val);
            end
        end
    end

    // {throttle, yaw, roll, pitch, frame_start, busy, in_ready}
    function automatic logic [6:0] model_outputs();
        logic [6:0] v;
        int d, s;
        v = '0;
        if (resetn) begin
            v[0] = ((cyc % F) != F - 1);
            if (base >= 0) begin
                d = cyc - base;
                s = 0;
                for (int k = 0; k < 4; k++) begin
                    if (d >= s && d < s + mw[k]) v[6 - k] = 1'b1;
                    s += mw[k];
                end
                v[2] = (d == 0);
                v[1] = (d < s);
            end
        end
        return v;
    endfunction

    function automatic logic [6:0] dut_outputs();
        return {bus.throttle_pwm, bus.yaw_pwm, bus.roll_pwm, bus.pitch_pwm,
                bus.frame_start, bus.busy, bus.in_ready};
    endfunction

    always @(negedge us_clk) begin
        logic [6:0] e, a;
        e = model_outputs();
        a = dut_outputs();
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL cycle_compare cyc=%0d t=%0t got=%b want=%b (tpwm,ypwm,rpwm,ppwm,fs,busy,rdy)",
                     cyc, $time, a, e);
        end
    end

    // ---------------- event recorder ----------------
    int rise_t [4][16];
    int fall_t [4][16];
    int rise_n [4];
    int fall_n [4];
    int fs_t   [16];
    int bf_t   [16];
    int fs_n, bf_n;
    logic [3:0] prev_pwm  = '0;
    logic       prev_busy = 1'b0;

    task automatic clear_events();
        for (int k = 0; k < 4; k++) begin
            rise_n[k] = 0;
            fall_n[k] = 0;
            for (int i = 0; i < 16; i++) begin
                rise_t[k][i] = -1;
                fall_t[k][i] = -1;
            end
        end
        for (int i = 0; i < 16; i++) begin
            fs_t[i] = -1;
            bf_t[i] = -1;
        end
        fs_n = 0;
        bf_n = 0;
    endtask

    always @(negedge us_clk) begin
        logic [3:0] cur;
        if (resetn) begin
            cur = {bus.pitch_pwm, bus.roll_pwm, bus.yaw_pwm, bus.throttle_pwm};
            for (int k = 0; k < 4; k++) begin
                if (cur[k] && !prev_pwm[k] && rise_n[k] < 16) begin
                    rise_t[k][rise_n[k]] = cyc;
                    rise_n[k]++;
                end
                if (!cur[k] && prev_pwm[k] && fall_n[k] < 16) begin
                    fall_t[k][fall_n[k]] = cyc;
                    fall_n[k]++;
                end
            end
            if (bus.frame_start && fs_n < 16) begin
                fs_t[fs_n] = cyc;
                fs_n++;
            end
            if (!bus.busy && prev_busy && bf_n < 16) begin
                bf_t[bf_n] = cyc;
                bf_n++;
            end
            prev_pwm  = cur;
            prev_busy = bus.busy;
        end else begin
            prev_pwm  = '0;
            prev_busy = 1'b0;
        end
    end

    // ---------------- stimulus and literal checks ----------------
    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) @(negedge us_clk);
    endtask

    task automatic set_vals(input int t, input int y, input int r, input int p);
        bus.throttle_val = 8'(t);
        bus.yaw_val      = 8'(y);
        bus.roll_val     = 8'(r);
        bus.pitch_val    = 8'(p);
    endtask

    initial begin
        clear_events();
        bus.in_valid = 1'b0;
        set_vals(0, 0, 0, 0);
        #1 resetn = 1'b0;
        repeat (3) @(negedge us_clk);
        check("reset_outputs", int'(dut_outputs()), 0);
        #2 resetn = 1'b1;

        // Frame 1 uses reset shadow (all zero); load new set mid-frame for frame 2.
        run_to(F + 100);
        set_vals(255, 1, 128, 64);
        bus.in_valid = 1'b1;
        @(negedge us_clk);
        bus.in_valid = 1'b0;

        // Hold in_valid across the load cycle before frame 3.
        run_to(3 * F - 1);
        check("in_ready_load_cycle", int'(bus.in_ready), 0);
        set_vals(10, 20, 30, 40);
        bus.in_valid = 1'b1;
        run_to(3 * F);
        check("in_ready_after_load", int'(bus.in_ready), 1);
        run_to(3 * F + 1);
        bus.in_valid = 1'b0;

        // Disable across the 5F load edge, re-enable before 6F.
        run_to(5 * F - 5);
        enable = 1'b0;
        run_to(5 * F + 10);
        enable = 1'b1;

        // Reset in the middle of frame 6's roll pulse (roll spans 6F+2120..6F+3239).
        run_to(6 * F + 2500);
        check("frame_count_before_reset", fs_n, 5);
        check("fs0", fs_t[0], F);
        check("fs1", fs_t[1], 2 * F);
        check("fs_spacing", fs_t[2] - fs_t[1], F);
        check("fs_after_disable", fs_t[4], 6 * F);
        check("f1_yaw_rise", rise_t[1][0], F + 1000);
        check("f1_roll_rise", rise_t[2][0], F + 2000);
        check("f1_pitch_rise", rise_t[3][0], F + 3000);
        check("f1_pitch_fall", fall_t[3][0], F + 4000);
        check("f2_throttle_w", fall_t[0][1] - rise_t[0][1], 2020);
        check("f2_yaw_w", fall_t[1][1] - rise_t[1][1], 1004);
        check("f2_roll_w", fall_t[2][1] - rise_t[2][1], 1512);
        check("f2_pitch_w", fall_t[3][1] - rise_t[3][1], 1256);
        check("f2_busy_fall", bf_t[1], 2 * F + 5792);
        check("f3_throttle_w_old", fall_t[0][2] - rise_t[0][2], 2020);
        check("f4_throttle_decode", (fall_t[0][3] - rise_t[0][3] - 1000) >> 2, 10);
        check("f4_yaw_decode", (fall_t[1][3] - rise_t[1][3] - 1000) >> 2, 20);
        check("f4_roll_decode", (fall_t[2][3] - rise_t[2][3] - 1000) >> 2, 30);
        check("f4_pitch_decode", (fall_t[3][3] - rise_t[3][3] - 1000) >> 2, 40);
        check("f6_roll_rise", rise_t[2][4], 6 * F + 2120);
        check("roll_high_before_reset", int'(bus.roll_pwm), 1);
        #2 resetn = 1'b0;
        #1 check("async_reset_outputs", int'(dut_outputs()), 0);
        repeat (3) @(negedge us_clk);
        clear_events();
        #2 resetn = 1'b1;

        run_to(F + 4100);
        check("post_reset_frames", fs_n, 1);
        check("post_reset_fs", fs_t[0], F);
        check("post_reset_throttle_w", fall_t[0][0] - rise_t[0][0], 1000);
        check("post_reset_pitch_rise", rise_t[3][0], F + 3000);
        check("post_reset_busy_fall", bf_t[0], F + 4000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
